usb_pd_pll_seq: RTL and testbench
=================================

Name: usb_pd_pll_seq

Overview:
Reset/lock sequencer for the USB-PD system PLL. It drives the PLL reset and watches its asynchronous lock output. It holds the downstream PD logic in reset until lock has been stable for a qualified interval. On timeout it retries a bounded number of times, then declares failure; loss of lock while running restarts the whole sequence. It runs on the free-running 50 MHz reference clock, because the PLL output is not valid until lock.

Parameters:
RST_HOLD_CYC, 50, refclk cycles the PLL reset is held high per attempt (1 us at 50 MHz); minimum 1.
LOCK_TIMEOUT_CYC, 50000, cycles to wait for lock after reset release before retrying (1 ms).
LOCK_STABLE_CYC, 1000, cycles the synchronized lock must stay high continuously before release.
MAX_RETRY, 3, retries allowed after the first attempt before FAIL; 0 to 15.
Counter width: $clog2 of the largest cycle parameter, plus 1.

Ports:
refclk  input  1  reference clock, 50 MHz, free-running
reset_n  input  1  asynchronous active-low reset
extlock  input  1  PLL lock flag, asynchronous to refclk
restart_req  input  1  single-cycle soft request to re-run the sequence
pll_reset  output  1  active-high reset to the PLL
sys_rst_n  output  1  active-low reset to the PD logic; high only in RUN
pll_ok  output  1  high in RUN
pll_fail  output  1  high in FAIL
retry_cnt  output  4  retries consumed in the current sequence
lost_cnt  output  8  saturating count of lock losses while in RUN

Behaviour:
- Interface: one clock, refclk. Reset reset_n is asynchronous, active-low. All flops clear on reset_n low.
- extlock goes through a 2-flop synchronizer to produce lock_s, giving 2 cycles of latency. The FSM uses only lock_s.
- All outputs are registered Moore outputs and update on the same edge as the state.
- Reset values: state=RESET_HOLD, cnt=0, pll_reset=1, sys_rst_n=0, pll_ok=0, pll_fail=0, retry_cnt=0, lost_cnt=0.
- cnt clears on every state entry.
- RESET_HOLD (pll_reset=1):
  - When cnt==RST_HOLD_CYC-1, go to WAIT_LOCK.
  - pll_reset is therefore high for exactly RST_HOLD_CYC cycles.
- WAIT_LOCK (pll_reset=0):
  - If lock_s, go to STABLE.
  - Else, when cnt==LOCK_TIMEOUT_CYC-1: if retry_cnt==MAX_RETRY, go to FAIL; otherwise retry_cnt+1 and go to RESET_HOLD.
  - lock_s wins over a simultaneous timeout.
- STABLE (pll_reset=0):
  - If lock_s is low, go to WAIT_LOCK; the timeout window restarts.
  - Else, when cnt==LOCK_STABLE_CYC-1, go to RUN.
- RUN (sys_rst_n=1, pll_ok=1):
  - If lock_s is low: lost_cnt+1 (saturates at 255), retry_cnt=0, go to RESET_HOLD.
  - sys_rst_n and pll_ok drop on the same edge.
- FAIL (pll_reset=1, pll_fail=1, sys_rst_n=0):
  - Stays here indefinitely.
  - Exits only on restart_req.
- restart_req:
  - Takes priority in every state, including over a simultaneous lock event or timeout.
  - Next state is RESET_HOLD, retry_cnt=0, pll_fail=0.
  - lost_cnt is not cleared.
  - A restart_req arriving in RESET_HOLD restarts the hold count.
- lock_s glitches in WAIT_LOCK or STABLE do not touch lost_cnt. Only a drop in RUN counts.
- A reset_n assertion mid-sequence returns every output to its reset value asynchronously.

Test Plan:
Bench parameters: RST_HOLD_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRY=2.
1. Nominal lock: release reset_n; extlock=1 from cycle 6 -> pll_reset high cycles 0-3; sys_rst_n=1 and pll_ok=1 exactly 8 cycles after lock_s first seen high; retry_cnt=0.
2. Timeout/retry/fail: extlock held 0 -> 3 attempts with retry_cnt 0→1→2 -> FAIL; pll_fail=1, pll_reset=1 held; restart_req then lock -> RUN with retry_cnt=0.
3. Unstable lock: extlock high for 5 cycles, low 1, then high -> FSM returns to WAIT_LOCK with no early release; final sys_rst_n rise 8 cycles after the last lock_s rise; lost_cnt=0.
4. Lock loss in RUN: drop extlock for 1 cycle -> sys_rst_n=0 and pll_reset=1 within 3 cycles of the drop; lost_cnt=1; relock -> RUN again.
5. Saturation and priority: 260 lock losses -> lost_cnt=255. Also, restart_req on the same cycle as a WAIT_LOCK timeout at retry_cnt=2 -> RESET_HOLD with retry_cnt=0, not FAIL.
6. Async reset mid-STABLE: pulse reset_n low -> immediately pll_reset=1 and all other outputs return to their reset values.

Source files
------------

// File: rtl/usb_pd_pll_seq.sv
// Reset/lock sequencer for the USB-PD system PLL: holds PLL reset, qualifies lock,
// retries on timeout, and gates the PD-domain reset on a stable lock.
module usb_pd_pll_seq #(
  parameter int RST_HOLD_CYC     = 50,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1000,
  parameter int MAX_RETRY        = 3
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       extlock,
  input  logic       restart_req,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       pll_ok,
  output logic       pll_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);
  localparam int MAX_A = (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ? RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_C = (MAX_A > LOCK_STABLE_CYC) ? MAX_A : LOCK_STABLE_CYC;
  localparam int CW    = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_d;
  logic [7:0]    lost_d;
  logic [1:0]    sync_q;
  logic          lock_s;

  // extlock is asynchronous to refclk; only the synchronized copy reaches the FSM
  always_ff @(posedge refclk or negedge reset_n)
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], extlock};

  assign lock_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_cnt;
    lost_d  = lost_cnt;
    if (restart_req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_HOLD:
          if (cnt_q == CW'(RST_HOLD_CYC - 1)) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        S_WAIT:
          if (lock_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT_CYC - 1)) begin
            cnt_d = '0;
            if (retry_cnt == 4'(MAX_RETRY)) state_d = S_FAIL;
            else begin
              state_d = S_HOLD;
              retry_d = retry_cnt + 4'd1;
            end
          end
        S_STABLE:
          if (!lock_s) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_STABLE_CYC - 1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        S_RUN: begin
          cnt_d = cnt_q;
          if (!lock_s) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            retry_d = 4'd0;
            lost_d  = (lost_cnt == 8'hFF) ? lost_cnt : lost_cnt + 8'd1;
          end
        end
        S_FAIL: cnt_d = cnt_q;
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state
  always_ff @(posedge refclk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      pll_ok    <= 1'b0;
      pll_fail  <= 1'b0;
      retry_cnt <= 4'd0;
      lost_cnt  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_reset <= (state_d == S_HOLD) || (state_d == S_FAIL);
      sys_rst_n <= (state_d == S_RUN);
      pll_ok    <= (state_d == S_RUN);
      pll_fail  <= (state_d == S_FAIL);
      retry_cnt <= retry_d;
      lost_cnt  <= lost_d;
    end
endmodule

// File: tb/tb_usb_pd_pll_seq.sv
// Randomized + directed bench for usb_pd_pll_seq against a cycle-level reference
// model of the sequencing rules.
module tb_usb_pd_pll_seq;
  localparam int HOLD = 4, TMO = 20, STB = 8, MAXR = 2;
  localparam logic [15:0] RST_V = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};

  logic refclk = 1'b0, reset_n = 1'b0, extlock = 1'b0, restart_req = 1'b0;
  logic pll_reset, sys_rst_n, pll_ok, pll_fail;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic [15:0] dut_v;

  int checks = 0, failures = 0;

  usb_pd_pll_seq #(.RST_HOLD_CYC(HOLD), .LOCK_TIMEOUT_CYC(TMO),
                   .LOCK_STABLE_CYC(STB), .MAX_RETRY(MAXR)) dut (
    .refclk(refclk), .reset_n(reset_n), .extlock(extlock), .restart_req(restart_req),
    .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .pll_ok(pll_ok), .pll_fail(pll_fail),
    .retry_cnt(retry_cnt), .lost_cnt(lost_cnt));

  always #5 refclk = ~refclk;

  assign dut_v = {pll_reset, sys_rst_n, pll_ok, pll_fail, retry_cnt, lost_cnt};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase of the sequence, cycles spent in it, and the lock
  // value as seen two refclk edges after extlock.
  localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;
  int m_phase, m_age, m_retry, m_lost;
  bit m_sync0, m_sync1;

  task automatic model_reset();
    m_phase = P_HOLD; m_age = 0; m_retry = 0; m_lost = 0; m_sync0 = 0; m_sync1 = 0;
  endtask

  task automatic go(input int p);
    m_phase = p; m_age = 0;
  endtask

  task automatic model_step(input bit ext, input bit rr);
    bit ls;
    ls = m_sync1; m_sync1 = m_sync0; m_sync0 = ext;
    if (rr) begin go(P_HOLD); m_retry = 0; end
    else if (m_phase == P_HOLD) begin
      if (m_age == HOLD - 1) go(P_WAIT); else m_age++;
    end else if (m_phase == P_WAIT) begin
      if (ls) go(P_STABLE);
      else if (m_age == TMO - 1) begin
        if (m_retry == MAXR) go(P_FAIL);
        else begin m_retry++; go(P_HOLD); end
      end else m_age++;
    end else if (m_phase == P_STABLE) begin
      if (!ls) go(P_WAIT);
      else if (m_age == STB - 1) go(P_RUN);
      else m_age++;
    end else if (m_phase == P_RUN && !ls) begin
      if (m_lost < 255) m_lost++;
      m_retry = 0;
      go(P_HOLD);
    end
  endtask

  function automatic logic [15:0] model_v();
    return {m_phase == P_HOLD || m_phase == P_FAIL, m_phase == P_RUN, m_phase == P_RUN,
            m_phase == P_FAIL, 4'(m_retry), 8'(m_lost)};
  endfunction

  // One refclk cycle: model advances on the edge, everything is compared on the falling edge
  task automatic cyc();
    @(posedge refclk);
    if (reset_n) model_step(extlock, restart_req);
    @(negedge refclk);
    chk("outs", 32'(dut_v), 32'(model_v()));
    restart_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("reset_vals", 32'(dut_v), 32'(RST_V));
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  task automatic drop_lock(output int n);
    extlock = 1'b0;
    cyc();
    n = 1;
    extlock = 1'b1;
    while (sys_rst_n && n < 20) begin cyc(); n++; end
  endtask

  task automatic wait_run(input int bound);
    int n;
    n = 0;
    while (!sys_rst_n && n < bound) begin cyc(); n++; end
    chk("reach_run", 32'(sys_rst_n), 32'd1);
  endtask

  initial begin
    int n;
    model_reset();
    @(negedge refclk);

    // Nominal lock
    do_reset();
    n = 0;
    while (pll_reset && n < 50) begin cyc(); n++; end
    chk("hold_len", n, HOLD);
    cyc(); cyc();
    extlock = 1'b1;
    n = 0;
    while (!sys_rst_n && n < 100) begin cyc(); n++; end
    chk("lock_to_run", n, 3 + STB);
    chk("run_ok", 32'(pll_ok), 32'd1);
    chk("run_retry", 32'(retry_cnt), 32'd0);

    // Timeout, retries, FAIL, restart
    do_reset();
    extlock = 1'b0;
    n = 0;
    while (!pll_fail && n < 400) begin cyc(); n++; end
    chk("fail_time", n, (MAXR + 1) * (HOLD + TMO));
    repeat (10) cyc();
    chk("fail_hold", 32'({pll_fail, pll_reset, sys_rst_n}), 32'b110);
    chk("fail_retry", 32'(retry_cnt), MAXR);
    restart_req = 1'b1;
    extlock = 1'b1;
    cyc();
    chk("restart_clr", 32'({pll_fail, retry_cnt}), 32'd0);
    wait_run(100);
    chk("restart_retry", 32'(retry_cnt), 32'd0);

    // Unstable lock in STABLE must not release early
    do_reset();
    extlock = 1'b0;
    repeat (HOLD + 3) cyc();
    extlock = 1'b1;
    repeat (5) begin cyc(); chk("no_early", 32'(sys_rst_n), 32'd0); end
    extlock = 1'b0;
    cyc();
    extlock = 1'b1;
    n = 0;
    while (!sys_rst_n && n < 100) begin cyc(); n++; end
    chk("relock_to_run", n, 3 + STB);
    chk("glitch_lost", 32'(lost_cnt), 32'd0);

    // Lock loss in RUN
    drop_lock(n);
    chk("drop_to_rst", n, 3);
    chk("drop_pllrst", 32'(pll_reset), 32'd1);
    chk("lost_one", 32'(lost_cnt), 32'd1);
    wait_run(100);

    // Saturation of lost_cnt
    for (int i = 0; i < 260; i++) begin
      drop_lock(n);
      wait_run(100);
    end
    chk("lost_sat", 32'(lost_cnt), 32'd255);

    // restart_req beats the final timeout
    do_reset();
    extlock = 1'b0;
    repeat ((MAXR + 1) * (HOLD + TMO) - 1) cyc();
    chk("pre_to_retry", 32'(retry_cnt), MAXR);
    restart_req = 1'b1;
    cyc();
    chk("prio_state", 32'({pll_fail, pll_reset, retry_cnt}), 32'b01_0000);
    repeat (30) cyc();

    // Async reset while in STABLE
    do_reset();
    extlock = 1'b1;
    repeat (HOLD + 4) cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst", 32'(dut_v), 32'(RST_V));
    model_reset();
    cyc();
    reset_n = 1'b1;
    wait_run(100);

    // Randomized lock activity with occasional restarts
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) extlock = ~extlock;
      if ($urandom_range(0, 59) == 0) restart_req = 1'b1;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
